// File: rtl/npu_sched_pkg.sv
// Shared types and geometry for the conv-window scheduler.
//   sched_state_e : scheduler FSM states
//   OUT_H / OUT_W : output positions per column / row of the image
//   K_W           : phase length (cycles per POS or NEG pass) and row-start fetch count
package npu_sched_pkg;

    localparam int unsigned IMG_H  = 16;
    localparam int unsigned IMG_W  = 15;
    localparam int unsigned K_H    = 3;
    localparam int unsigned K_W    = 3;
    localparam int unsigned CHAN   = 10;
    localparam int unsigned ADDR_W = 16;

    localparam int unsigned OUT_H  = IMG_H - K_H + 1;
    localparam int unsigned OUT_W  = IMG_W - K_W + 1;

    // Width of a position counter (chan/row/col)
    localparam int unsigned POS_W  = 8;
    // Holds 0..K_W for both the fetch and phase counters
    localparam int unsigned CNT_W  = $clog2(K_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CLR,
        S_POS,
        S_NEG,
        S_EMIT,
        S_DONE
    } sched_state_e;

endpackage

// File: rtl/conv_win_sched_pos.sv
// Nested chan/row/col output-position counter.
//   clk, rst      : clock, async active-high reset
//   clr_i         : synchronous clear to (0,0,0)
//   adv_i         : step to the next output position (col fastest)
//   chan_o/row_o/col_o          : current position
//   chan_last_o/row_last_o/col_last_o : position is at the last value of that axis
module win_pos_cnt
    import npu_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [POS_W-1:0] chan_o,
    output logic [POS_W-1:0] row_o,
    output logic [POS_W-1:0] col_o,
    output logic             chan_last_o,
    output logic             row_last_o,
    output logic             col_last_o
);

    logic [POS_W-1:0] chan_q, chan_d;
    logic [POS_W-1:0] row_q,  row_d;
    logic [POS_W-1:0] col_q,  col_d;
    logic             chan_last_q, row_last_q, col_last_q;

    // Advance with carry; the final position holds rather than wrapping
    always_comb begin
        chan_d = chan_q;
        row_d  = row_q;
        col_d  = col_q;
        if (clr_i) begin
            chan_d = '0;
            row_d  = '0;
            col_d  = '0;
        end else if (adv_i && !(col_last_q && row_last_q && chan_last_q)) begin
            if (!col_last_q) begin
                col_d = col_q + POS_W'(1);
            end else begin
                col_d = '0;
                if (!row_last_q) begin
                    row_d = row_q + POS_W'(1);
                end else begin
                    row_d  = '0;
                    chan_d = chan_q + POS_W'(1);
                end
            end
        end
    end

    // Position and last-flags registered together so flags track the counters exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            chan_last_q <= 1'b0;
            row_last_q  <= 1'b0;
            col_last_q  <= 1'b0;
        end else begin
            chan_q      <= chan_d;
            row_q       <= row_d;
            col_q       <= col_d;
            chan_last_q <= (chan_d == POS_W'(CHAN - 1));
            row_last_q  <= (row_d  == POS_W'(OUT_H - 1));
            col_last_q  <= (col_d  == POS_W'(OUT_W - 1));
        end
    end

    assign chan_o      = chan_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign chan_last_o = chan_last_q;
    assign row_last_o  = row_last_q;
    assign col_last_o  = col_last_q;

endmodule

// File: rtl/conv_win_sched.sv
// Self-sequencing scheduler for the conv layer: fetches image columns, runs the
// PE array through clear / positive pass / negated pass, and hands out one result
// per output window, sweeping every (chan, row, col).
//   clk, rst                : clock, async active-high reset
//   start / abort           : run trigger / synchronous abort back to idle
//   busy / done             : run in progress / one-cycle end-of-sweep pulse
//   rd_req, rd_addr, rd_ack : column fetch handshake; col_load = rd_req & rd_ack
//   w_shift, pe_clr, pe_en, neg_phase : PE array and weight register controls
//   out_valid, out_ready, out_row/out_col/out_chan : result handshake and position
// Optional: define CONV_WIN_SCHED_PERF_EN to add perf_cycles / perf_stall counters.
module conv_win_sched
    import npu_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              col_load,
    output logic              w_shift,
    output logic              pe_clr,
    output logic              pe_en,
    output logic              neg_phase,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic [7:0]        out_chan
`ifdef CONV_WIN_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;     // fetches still to issue for this window
    logic [CNT_W-1:0]  ph_q, ph_d;         // cycle within POS / NEG pass
    logic [ADDR_W-1:0] addr_q, addr_d;     // next column word to fetch
    logic              pos_clr, pos_adv;
    logic              chan_last, row_last, col_last;

    logic busy_q, done_q, rd_req_q, w_shift_q, pe_clr_q, pe_en_q, neg_q, valid_q;
    logic busy_d, done_d, rd_req_d, w_shift_d, pe_clr_d, pe_en_d, neg_d, valid_d;

    win_pos_cnt u_pos (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pos_clr),
        .adv_i      (pos_adv),
        .chan_o     (out_chan),
        .row_o      (out_row),
        .col_o      (out_col),
        .chan_last_o(chan_last),
        .row_last_o (row_last),
        .col_last_o (col_last)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            ph_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            ph_q    <= ph_d;
            addr_q  <= addr_d;
        end
    end

    // Next state. Fetch addresses are consecutive within a channel sweep (window
    // slide and row wrap both land on the word after the last fetched), so the
    // address only advances on ack and rewinds to 0 when a channel sweep ends.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        ph_d    = ph_q;
        addr_d  = addr_q;
        pos_clr = 1'b0;
        pos_adv = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
            ph_d    = '0;
            addr_d  = '0;
            pos_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        fcnt_d  = CNT_W'(K_W);
                        addr_d  = '0;
                        pos_clr = 1'b1;
                    end
                end
                S_FETCH: begin
                    if (rd_ack) begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (fcnt_q == CNT_W'(1)) begin
                            state_d = S_CLR;
                            fcnt_d  = '0;
                        end else begin
                            fcnt_d = fcnt_q - CNT_W'(1);
                        end
                    end
                end
                S_CLR: begin
                    state_d = S_POS;
                    ph_d    = '0;
                end
                S_POS: begin
                    if (ph_q == CNT_W'(K_W - 1)) begin
                        state_d = S_NEG;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + CNT_W'(1);
                    end
                end
                S_NEG: begin
                    if (ph_q == CNT_W'(K_W - 1)) begin
                        state_d = S_EMIT;
                        ph_d    = '0;
                    end else begin
                        ph_d = ph_q + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (col_last && row_last && chan_last) begin
                            state_d = S_DONE;
                            addr_d  = '0;
                            pos_clr = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            pos_adv = 1'b1;
                            fcnt_d  = col_last ? CNT_W'(K_W) : CNT_W'(1);
                            if (col_last && row_last) begin
                                addr_d = '0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs align with state_q
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        rd_req_d  = 1'b0;
        w_shift_d = 1'b0;
        pe_clr_d  = 1'b0;
        pe_en_d   = 1'b0;
        neg_d     = 1'b0;
        valid_d   = 1'b0;
        case (state_d)
            S_FETCH: rd_req_d = 1'b1;
            S_CLR:   pe_clr_d = 1'b1;
            S_POS: begin
                pe_en_d   = 1'b1;
                w_shift_d = 1'b1;
            end
            S_NEG: begin
                pe_en_d   = 1'b1;
                w_shift_d = 1'b1;
                neg_d     = 1'b1;
            end
            S_EMIT:  valid_d = 1'b1;
            S_DONE:  done_d  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            w_shift_q <= 1'b0;
            pe_clr_q  <= 1'b0;
            pe_en_q   <= 1'b0;
            neg_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_req_q  <= rd_req_d;
            w_shift_q <= w_shift_d;
            pe_clr_q  <= pe_clr_d;
            pe_en_q   <= pe_en_d;
            neg_q     <= neg_d;
            valid_q   <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = addr_q;
    assign col_load  = rd_req_q & rd_ack;
    assign w_shift   = w_shift_q;
    assign pe_clr    = pe_clr_q;
    assign pe_en     = pe_en_q;
    assign neg_phase = neg_q;
    assign out_valid = valid_q;

`ifdef CONV_WIN_SCHED_PERF_EN
    logic [31:0] pcyc_q, pstall_q;
    logic        stall_c;

    assign stall_c = ((state_q == S_FETCH) && !rd_ack) || ((state_q == S_EMIT) && !out_ready);

    // Saturating busy-cycle and stall-cycle counters, cleared on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else if ((state_q == S_IDLE) && start && !abort) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (pcyc_q != '1)) begin
                pcyc_q <= pcyc_q + 32'(1);
            end
            if (stall_c && (pstall_q != '1)) begin
                pstall_q <= pstall_q + 32'(1);
            end
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stall  = pstall_q;
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// Bench for conv_win_sched: a responder drives rd_ack / out_ready with chosen
// delays while the expected fetch-address and window order come from plain
// nested loops over the output geometry.
module tb_conv_win_sched;
    import npu_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, abort, rd_ack, out_ready;
    logic              busy, done, rd_req, col_load, w_shift, pe_clr, pe_en, neg_phase, out_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        out_row, out_col, out_chan;
`ifdef CONV_WIN_SCHED_PERF_EN
    logic [31:0]       perf_cycles, perf_stall;
`endif

    conv_win_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .col_load(col_load), .w_shift(w_shift), .pe_clr(pe_clr), .pe_en(pe_en),
        .neg_phase(neg_phase), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_chan(out_chan)
`ifdef CONV_WIN_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference sequences
    int          exp_addr[$];
    logic [23:0] exp_win[$];

    // Run bookkeeping
    int          cyc, ack_wait, ack_dly, rdy_wait, rdy_dly;
    int          n_clr, n_en, n_neg, n_done, n_acc, n_vs, n_fetch;
    int          first_v[2];
    int          ack_mode, rdy_mode, start_at;
    bit          stray_ready, start_req, abort_req, abort_arm, abort_fired, perf_chk;
    logic [15:0] held_addr;
    logic [23:0] held_pos, last_pos;

    function automatic void new_run();
        exp_addr.delete();
        exp_win.delete();
        for (int ch = 0; ch < int'(CHAN); ch++)
            for (int r = 0; r < int'(OUT_H); r++)
                for (int c = 0; c < int'(OUT_W); c++) begin
                    if (c == 0)
                        for (int k = 0; k < int'(K_W); k++) exp_addr.push_back(r * int'(IMG_W) + k);
                    else
                        exp_addr.push_back(r * int'(IMG_W) + c + int'(K_W) - 1);
                    exp_win.push_back({8'(ch), 8'(r), 8'(c)});
                end
        ack_wait = 0; rdy_wait = 0; n_clr = 0; n_en = 0; n_neg = 0;
        n_done = 0; n_acc = 0; n_vs = 0; n_fetch = 0;
        first_v[0] = -1; first_v[1] = -1;
        abort_fired = 0; start_at = -1;
    endfunction

    function automatic int pick_ack();
        case (ack_mode)
            1:       return 3;
            2:       return (n_fetch == 0) ? 2 : 0;
            3:       return int'($urandom_range(0, 2));
            default: return 0;
        endcase
    endfunction

    function automatic int pick_rdy(input logic [23:0] pos);
        if (rdy_mode == 0) return 0;
        if (pos == 24'h000004) return 5;
        return int'($urandom_range(0, 2));
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({busy, done, rd_req, col_load, w_shift, pe_clr, pe_en, neg_phase, out_valid,
                    rd_addr, out_row, out_col, out_chan});
    endfunction

    // One clock of observation and response, at the falling edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (start_req && !busy && !abort_req) cyc = 0;
        start = start_req;
        abort = abort_req;
        start_req = 0;
        abort_req = 0;

        if (pe_clr) n_clr++;
        if (pe_en) n_en++;
        if (pe_en && neg_phase) n_neg++;
        if (pe_en || w_shift) check("w_shift", w_shift, pe_en);
        if (neg_phase) check("neg_en", pe_en, 1);
        if (done) begin
            n_done++;
            check("done_busy", busy, 1);
        end

        if (ack_wait != 0) check("req_hold", rd_req, 1);
        if (rd_req) begin
            if (ack_wait == 0) begin
                held_addr = rd_addr;
                ack_dly   = pick_ack();
            end else begin
                check("addr_hold", rd_addr, held_addr);
            end
            if (ack_wait >= ack_dly) begin
                rd_ack = 1'b1;
                check("addr_avail", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) check("rd_addr", rd_addr, 64'(exp_addr.pop_front()));
                n_fetch++;
                ack_wait = 0;
            end else begin
                rd_ack = 1'b0;
                ack_wait++;
            end
        end else begin
            rd_ack = (ack_mode == 0);
        end

        if (rdy_wait != 0) check("valid_hold", out_valid, 1);
        if (out_valid) begin
            if (rdy_wait == 0) begin
                held_pos = {out_chan, out_row, out_col};
                check("win_avail", exp_win.size() > 0, 1);
                if (exp_win.size() > 0) check("win_pos", held_pos, exp_win[0]);
                check("n_clr", n_clr, 1);
                check("n_en", n_en, 2 * K_W);
                check("n_neg", n_neg, K_W);
                if (n_vs < 2) first_v[n_vs] = cyc;
`ifdef CONV_WIN_SCHED_PERF_EN
                if (perf_chk && n_vs == 0) begin
                    check("perf_stall", perf_stall, 2);
                    check("perf_cycles", perf_cycles, 64'(cyc - 1));
                end
`endif
                n_vs++;
                rdy_dly = pick_rdy(held_pos);
            end else begin
                check("pos_hold", {out_chan, out_row, out_col}, held_pos);
                check("stall_quiet", {pe_en, rd_req, pe_clr}, 0);
            end
            if (rdy_wait >= rdy_dly) begin
                out_ready = 1'b1;
                rdy_wait  = 0;
                n_acc++;
                last_pos  = held_pos;
                if (exp_win.size() > 0) void'(exp_win.pop_front());
                n_clr = 0; n_en = 0; n_neg = 0;
            end else begin
                out_ready = 1'b0;
                rdy_wait++;
            end
        end else begin
            out_ready = stray_ready ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
        end

        if (abort_arm && pe_en && !neg_phase && {out_chan, out_row, out_col} == 24'h020507) begin
            abort       = 1'b1;
            abort_arm   = 0;
            abort_fired = 1;
        end
        if (abort) begin
            ack_wait = 0;
            rdy_wait = 0;
        end
        if (cyc == start_at) start_req = 1;

        #1;
        if (rd_req) check("col_load", col_load, rd_ack);
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        step();
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        check("run_bound", busy, 0);
    endtask

    task automatic abort_now();
        abort_req = 1;
        step();
        step();
        check("abort_idle", busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 0; abort = 0; rd_ack = 0; out_ready = 0;
        cyc = 0; ack_mode = 0; rdy_mode = 0; stray_ready = 0;
        start_req = 0; abort_req = 0; abort_arm = 0; perf_chk = 0;
        held_addr = '0; held_pos = '0; last_pos = '0;
        new_run();
        repeat (3) @(negedge clk);
        check("reset_outs", outs_vec(), 0);
        rst = 1'b0;
        step();
        check("idle_outs", outs_vec(), 0);

        // Full sweep, ack/ready tied high, with a stray start mid-run
        new_run();
        start_at = 50;
        start_req = 1;
        step();
        run_until_idle(30000);
        check("first_valid_cyc", first_v[0], 11);
        check("second_valid_cyc", first_v[1], 20);
        check("accepts", n_acc, CHAN * OUT_H * OUT_W);
        check("last_pos", last_pos, {8'd9, 8'd13, 8'd12});
        check("fetches", n_fetch, CHAN * OUT_H * (K_W + OUT_W - 1));
        check("addr_left", exp_addr.size(), 0);
        check("win_left", exp_win.size(), 0);
        check("done_pulses", n_done, 1);
        repeat (3) step();
        check("post_busy", busy, 0);
        check("post_done", done, 0);

        // Ack delayed 3 on every fetch, random ready with a 5-cycle stall at (0,0,4)
        new_run();
        ack_mode = 1; rdy_mode = 1; stray_ready = 1;
        start_req = 1;
        step();
        n = 0;
        while (n_acc < 200 && n < 20000) begin
            step();
            n++;
        end
        check("delay_reached", n_acc >= 200, 1);
        check("delay_dones", n_done, 0);
        abort_now();

        // Abort in POS of window (2,5,7)
        new_run();
        ack_mode = 0; rdy_mode = 0; stray_ready = 0;
        abort_arm = 1;
        start_req = 1;
        step();
        n = 0;
        while (!abort_fired && n < 10000) begin
            step();
            n++;
        end
        check("abort_reached", abort_fired, 1);
        step();
        check("abort_outs", outs_vec(), 0);
        repeat (20) step();
        check("abort_no_done", n_done, 0);
        check("abort_stays_idle", busy, 0);

        // Abort and start together in idle
        start_req = 1; abort_req = 1;
        step();
        step();
        check("abort_start", busy, 0);

        // Fresh start after abort restarts at (0,0,0)
        new_run();
        start_req = 1;
        step();
        n = 0;
        while (n_vs < 1 && n < 50) begin
            step();
            n++;
        end
        check("restart_valid_cyc", first_v[0], 11);
        check("restart_pos", held_pos, 0);
        abort_now();

        // Asynchronous reset while a fetch is waiting
        new_run();
        ack_mode = 1;
        start_req = 1;
        step();
        n = 0;
        while (!(rd_req && ack_wait == 2) && n < 50) begin
            step();
            n++;
        end
        check("rst_req_before", rd_req, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_rd_req", rd_req, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        new_run();
        ack_mode = 0;
        step();
        check("rst_outs", outs_vec(), 0);

`ifdef CONV_WIN_SCHED_PERF_EN
        // Two stall cycles on the first fetch only
        new_run();
        ack_mode = 2; rdy_mode = 0; perf_chk = 1;
        start_req = 1;
        step();
        n = 0;
        while (n_vs < 1 && n < 50) begin
            step();
            n++;
        end
        check("perf_valid_seen", n_vs, 1);
        perf_chk = 0;
        abort_now();
`endif

        // Random ack delays with free-running ready, short run
        new_run();
        ack_mode = 3; rdy_mode = 1; stray_ready = 1;
        start_req = 1;
        step();
        n = 0;
        while (n_acc < 60 && n < 5000) begin
            step();
            n++;
        end
        check("rand_reached", n_acc >= 60, 1);
        abort_now();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
